// File: rtl/shift_sequencer_if.sv
// Request/response bundle between a requester and the shift sequencer.
// Carries the request channel, the response channel and the busy status.
// The master drives requests and takes results; the slave is the sequencer.
interface shift_sequencer_if #(
  parameter int WIDTH = 16
) ();
  localparam int CNT_W = $clog2(WIDTH);

  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_data;
  logic [CNT_W-1:0] req_cnt;
  logic [1:0]       req_op;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             busy;

  modport master (
    output req_valid, req_data, req_cnt, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, busy
  );

  modport slave (
    input  req_valid, req_data, req_cnt, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_data, busy
  );
endinterface

// File: rtl/shift_sequencer.sv
// Multi-cycle shift/rotate unit reusing one 1/2/4/8 power-of-two shift stage.
// Latency: CNT_W cycles from the accept edge to rsp_valid, independent of count and op.
// Backpressure: result held in DONE until rsp_ready; req_ready low while busy unless the result drains.
module shift_sequencer #(
  parameter int WIDTH = 16
) (
  input logic             clk,
  input logic             rst_n,
  shift_sequencer_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH);
  localparam int LAST  = CNT_W - 1;
  localparam logic [CNT_W-1:0] LAST_STAGE = LAST[CNT_W-1:0];

  localparam logic [1:0] OP_ROL = 2'b00;
  localparam logic [1:0] OP_SLL = 2'b01;
  localparam logic [1:0] OP_ROR = 2'b10;
  localparam logic [1:0] OP_SRL = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] stage_q;
  logic [WIDTH-1:0] data_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       op_q;

  logic             req_ready;
  logic             load;
  logic             step;
  logic [CNT_W-1:0] amt;
  logic             stage_en;
  logic [WIDTH-1:0] stage_res;

  // Ready is purely a function of state and rsp_ready, never of req_valid.
  assign req_ready = (state_q == IDLE) || ((state_q == DONE) && bus.rsp_ready);

  // Shared shift stage: amount 2^stage, applied only when the matching count bit is set.
  always_comb begin
    amt       = CNT_W'(1) << stage_q;
    stage_en  = |(cnt_q & amt);
    stage_res = data_q;
    if (stage_en) begin
      case (op_q)
        OP_ROL:  stage_res = (data_q << amt) | (data_q >> (WIDTH - int'(amt)));
        OP_SLL:  stage_res = data_q << amt;
        OP_ROR:  stage_res = (data_q >> amt) | (data_q << (WIDTH - int'(amt)));
        OP_SRL:  stage_res = data_q >> amt;
        default: stage_res = data_q;
      endcase
    end
  end

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          load    = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        step = 1'b1;
        if (stage_q == LAST_STAGE) state_d = DONE;
      end
      DONE: begin
        if (bus.rsp_ready) begin
          if (bus.req_valid) begin
            load    = 1'b1;
            state_d = SHIFT;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand capture on accept, then one stage per cycle while shifting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
    end else if (load) begin
      stage_q <= '0;
      data_q  <= bus.req_data;
      cnt_q   <= bus.req_cnt;
      op_q    <= bus.req_op;
    end else if (step) begin
      stage_q <= stage_q + 1'b1;
      data_q  <= stage_res;
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = (state_q == DONE);
  assign bus.rsp_data  = data_q;
  assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: hand-computed results and latencies.
// Covers reset, all four ops, count extremes, held responses, back-to-back and abort.
// Inputs change 1 ns after the rising edge; outputs are sampled at the same point.
module tb_shift_sequencer;
  localparam logic [1:0] ROL = 2'b00;
  localparam logic [1:0] SLL = 2'b01;
  localparam logic [1:0] ROR = 2'b10;
  localparam logic [1:0] SRL = 2'b11;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  shift_sequencer_if #(.WIDTH(16)) bus ();

  shift_sequencer #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Counts cycles until rsp_valid, bounded so a stuck DUT still ends the run.
  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!bus.rsp_valid && lat < 20) begin
      step();
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [15:0] d,
                        input logic [3:0] c, input logic [15:0] exp);
    int lat;
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_data  = d;
    bus.req_cnt   = c;
    check({tag, "_rdy"}, bus.req_ready, 1);
    step();
    // Garbage on the request bus after accept must be ignored.
    bus.req_valid = 1'b0;
    bus.req_data  = ~d;
    bus.req_cnt   = ~c;
    bus.req_op    = ~op;
    check({tag, "_busy"}, bus.busy, 1);
    wait_rsp(lat);
    check({tag, "_lat"}, lat, 4);
    check({tag, "_dat"}, bus.rsp_data, exp);
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    check({tag, "_idle"}, {bus.rsp_valid, bus.busy, bus.req_ready}, 3'b001);
  endtask

  initial begin
    int lat;
    int seen;
    rst_n         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_data  = '0;
    bus.req_cnt   = '0;
    bus.req_op    = '0;
    bus.rsp_ready = 1'b0;
    #1;
    check("rst_vld",  bus.rsp_valid, 0);
    check("rst_dat",  bus.rsp_data, 16'h0000);
    check("rst_busy", bus.busy, 0);
    check("rst_rdy",  bus.req_ready, 1);
    step();
    step();
    rst_n = 1'b1;
    step();

    // T1..T3 plus extra directed vectors
    run_op("t1_sll",    SLL, 16'h0001, 4'd4,  16'h0010);
    run_op("t2_rol",    ROL, 16'h8001, 4'd1,  16'h0003);
    run_op("t2_ror",    ROR, 16'h1234, 4'd8,  16'h3412);
    run_op("t3_srl",    SRL, 16'h8000, 4'd15, 16'h0001);
    run_op("t3_sll0",   SLL, 16'hFFFF, 4'd0,  16'hFFFF);
    run_op("ror_wrap",  ROR, 16'h0001, 4'd1,  16'h8000);
    run_op("sll_5",     SLL, 16'h8421, 4'd5,  16'h8420);
    run_op("srl_3",     SRL, 16'hF0F0, 4'd3,  16'h1E1E);
    run_op("rol_12",    ROL, 16'h1234, 4'd12, 16'h4123);

    // T4: result held under backpressure
    bus.req_valid = 1'b1;
    bus.req_op    = ROL;
    bus.req_data  = 16'h00F0;
    bus.req_cnt   = 4'd4;
    step();
    bus.req_valid = 1'b0;
    wait_rsp(lat);
    check("t4_lat", lat, 4);
    for (int i = 0; i < 3; i++) begin
      check("t4_hold_dat", bus.rsp_data, 16'h0F00);
      check("t4_hold_vld", bus.rsp_valid, 1);
      check("t4_hold_rdy", bus.req_ready, 0);
      step();
    end
    bus.rsp_ready = 1'b1;
    #1;
    check("t4_rdy_comb", bus.req_ready, 1);
    step();
    bus.rsp_ready = 1'b0;
    check("t4_idle", {bus.rsp_valid, bus.busy, bus.req_ready}, 3'b001);

    // T5: back-to-back accept in the DONE cycle
    bus.req_valid = 1'b1;
    bus.req_op    = SLL;
    bus.req_data  = 16'h00F0;
    bus.req_cnt   = 4'd4;
    step();
    bus.req_valid = 1'b0;
    wait_rsp(lat);
    check("t5a_lat", lat, 4);
    check("t5a_dat", bus.rsp_data, 16'h0F00);
    bus.rsp_ready = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_op    = SRL;
    bus.req_data  = 16'h0F00;
    bus.req_cnt   = 4'd8;
    #1;
    check("t5_rdy", bus.req_ready, 1);
    step();
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b0;
    check("t5_shift", {bus.rsp_valid, bus.busy}, 2'b01);
    wait_rsp(lat);
    check("t5b_lat", lat, 4);
    check("t5b_dat", bus.rsp_data, 16'h000F);
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    check("t5_idle", {bus.rsp_valid, bus.busy, bus.req_ready}, 3'b001);

    // T6: reset two cycles into SHIFT aborts the operation
    bus.req_valid = 1'b1;
    bus.req_op    = ROL;
    bus.req_data  = 16'hA5A5;
    bus.req_cnt   = 4'd3;
    step();
    bus.req_valid = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    #1;
    check("t6_vld", bus.rsp_valid, 0);
    check("t6_dat", bus.rsp_data, 16'h0000);
    check("t6_busy", bus.busy, 0);
    check("t6_rdy", bus.req_ready, 1);
    step();
    step();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.rsp_valid) seen++;
      step();
    end
    check("t6_no_rsp", seen, 0);
    run_op("t6_after", SRL, 16'hA5A5, 4'd4, 16'h0A5A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
